inst_decode_buffer: RTL and testbench
=====================================

Name: inst_decode_buffer

Overview:
Parametrised decode-and-queue stage between fetch and issue. Accepts raw RV32I instruction words with their PC over a valid/ready handshake and decodes them into register indices, a format class and a fully sign-extended 32-bit immediate for every RV32I format. Decoded entries are held in a DEPTH-entry circular FIFO and presented to issue over a second valid/ready handshake. A flush input supports branch redirect.

Parameters:
DEPTH, 4, number of FIFO entries; power of two, 2..16.
XLEN, 32, PC and immediate width; fixed at 32, elaboration error otherwise.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  discard all queued entries and any input accepted this cycle
in_valid  in  1  fetch offers an instruction
in_ready  out  1  buffer can accept; high iff count < DEPTH
in_inst  in  32  raw instruction word
in_pc  in  XLEN  instruction address
out_valid  out  1  head entry present; high iff count != 0
out_ready  in  1  issue consumes head
out_pc  out  XLEN  head PC
out_format  out  3  head format class (inst_decode_pkg::format_t)
out_rd  out  5  inst[11:7]
out_rs1  out  5  inst[19:15]
out_rs2  out  5  inst[24:20]
out_imm  out  XLEN  sign-extended immediate
out_illegal  out  1  head word failed decode
out_count  out  $clog2(DEPTH+1)  occupancy

Behaviour:
- Reset (async assert, sync release): count=0, rd/wr pointers=0, out_valid=0, in_ready=1, out_count=0. Storage contents are don't-care; all out_* data fields read 0 while empty.
- Decode is combinational on in_inst; the decoded entry is written at the push edge. Push = in_valid & in_ready & ~flush. Pop = out_valid & out_ready & ~flush.
- Latency: an entry pushed at edge N is visible with out_valid=1 after edge N (1 cycle). Head fields are read combinationally from storage at rd_ptr.
- Format by opcode inst[6:0]:
  - 0110111 / 0010111 → U: imm = {inst[31:12], 12'b0}.
  - 1101111 → J: imm = sext{inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - 1100111 / 0000011 / 0010011 / 1110011 → I: imm = sext inst[31:20].
  - 1100011 → B: imm = sext{inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - 0100011 → S: imm = sext{inst[31:25], inst[11:7]}.
  - 0110011 → R: imm = 0.
  - 0001111 → FENCE, treated as I.
- out_illegal=1 if inst[1:0] != 2'b11 or the opcode is not in the list above. The entry is still queued with format ILLEGAL and imm=0; issue raises the trap.
- rd/rs1/rs2 are always extracted raw. Issue ignores them per format.
- Simultaneous push and pop when 0 < count < DEPTH: count unchanged, both pointers advance.
- When full, in_ready=0 even if out_ready=1. There is no combinational path from out_ready to in_ready.
- When empty, pop is impossible. There is no bypass: a same-cycle push does not appear until the next cycle.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- flush: at the edge, count and both pointers reset to 0. A concurrent push and pop are both ignored. out_valid=0 the next cycle, and in_ready stays 1 in the flush cycle.
- Reset asserted mid-operation: all state clears immediately, without waiting for an edge.

Decomposition:
- Package inst_decode_pkg:
  - format_t enum: R, I, S, B, U, J, ILLEGAL.
  - Opcode localparams.
  - entry_t packed struct: pc, format, rd, rs1, rs2, imm, illegal.
  - Immediate-field bit positions.
- Sub-module inst_immediate_gen: combinational, inst → {format, imm, illegal}. It is instantiated once on the push side. The FIFO stores entry_t.

Test Plan:
- Push 0xFFF00093 (addi x1,x0,-1), PC 0x100, out_ready=1 → next cycle: out_valid=1, format I, rd=1, rs1=0, imm=0xFFFFFFFF, pc=0x100, illegal=0.
- Push in sequence: 0x123452B7 (lui x5), 0xFE208EE3 (beq x1,x2,-4), 0x0020A423 (sw x2,8(x1)) → in order:
  - U, rd=5, imm=0x12345000
  - B, rs1=1, rs2=2, imm=0xFFFFFFFC
  - S, imm=0x00000008
- DEPTH=4, out_ready=0, push 5 words back-to-back → in_ready falls after the 4th accept, out_count=4, 5th held. Then out_ready=1 → FIFO order preserved, in_ready=1 after first pop; push+pop at count=2 keeps out_count=2.
- Wrap: 10 pushes and pops with out_ready toggling every other cycle → output sequence equals input sequence; the pointer wrap is exercised.
- With count=3, assert flush alongside in_valid=1 and out_ready=1 → next cycle out_count=0, out_valid=0, and the flushed-cycle input is absent from later output.
- Push 0x00000000, then 0x0000007F → both produce illegal=1, format ILLEGAL, imm=0. Assert rst mid-stream with count=2 → out_valid=0 and in_ready=1 before the next edge.

Source files
------------

// File: rtl/inst_decode_pkg.sv
// Shared types for the RV32I decode-and-queue stage: format classes, opcodes and the
// decoded FIFO entry layout.
package inst_decode_pkg;

  localparam int unsigned Xlen = 32;

  typedef enum logic [2:0] {
    R       = 3'd0,
    I       = 3'd1,
    S       = 3'd2,
    B       = 3'd3,
    U       = 3'd4,
    J       = 3'd5,
    ILLEGAL = 3'd6
  } format_t;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  // Instruction-word bit positions used by the decoder
  localparam int unsigned OpcodeMsb  = 6;
  localparam int unsigned RdLsb      = 7;
  localparam int unsigned Rs1Lsb     = 15;
  localparam int unsigned Rs2Lsb     = 20;
  localparam int unsigned ImmSignBit = 31;
  localparam int unsigned UImmLsb    = 12;

  typedef struct packed {
    logic [Xlen-1:0] pc;
    format_t         format;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [Xlen-1:0] imm;
    logic            illegal;
  } entry_t;

endpackage

// File: rtl/inst_immediate_gen.sv
// Combinational RV32I format classifier and sign-extended immediate generator.
module inst_immediate_gen
  import inst_decode_pkg::*;
(
  input  logic [31:0]     i_inst,
  output format_t         o_format,
  output logic [Xlen-1:0] o_imm,
  output logic            o_illegal
);

  logic w_sign;
  assign w_sign = i_inst[ImmSignBit];

  always_comb begin
    o_format  = ILLEGAL;
    o_imm     = '0;
    o_illegal = 1'b1;
    if (i_inst[1:0] == 2'b11) begin
      case (i_inst[OpcodeMsb:0])
        OpLui, OpAuipc: begin
          o_format  = U;
          o_imm     = {i_inst[31:UImmLsb], 12'b0};
          o_illegal = 1'b0;
        end
        OpJal: begin
          o_format  = J;
          o_imm     = {{11{w_sign}}, w_sign, i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
          o_illegal = 1'b0;
        end
        OpJalr, OpLoad, OpImm, OpSystem, OpFence: begin
          o_format  = I;
          o_imm     = {{20{w_sign}}, i_inst[31:20]};
          o_illegal = 1'b0;
        end
        OpBranch: begin
          o_format  = B;
          o_imm     = {{19{w_sign}}, w_sign, i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
          o_illegal = 1'b0;
        end
        OpStore: begin
          o_format  = S;
          o_imm     = {{20{w_sign}}, i_inst[31:25], i_inst[11:7]};
          o_illegal = 1'b0;
        end
        OpReg: begin
          o_format  = R;
          o_imm     = '0;
          o_illegal = 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/inst_decode_buffer.sv
// Decode stage between fetch and issue: decodes RV32I words on push and queues them in a
// DEPTH-entry circular FIFO, with flush for branch redirect.
module inst_decode_buffer
  import inst_decode_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_inst,
  input  logic [XLEN-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output format_t                    out_format,
  output logic [4:0]                 out_rd,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [XLEN-1:0]            out_imm,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH+1)-1:0] out_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);

  if (XLEN != Xlen) begin : g_xlen_check
    $error("inst_decode_buffer: XLEN must be 32");
  end
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("inst_decode_buffer: DEPTH must be a power of two in 2..16");
  end

  format_t         w_format;
  logic [XLEN-1:0] w_imm;
  logic            w_illegal;
  entry_t          w_entry;
  entry_t          w_head;
  logic            w_push;
  logic            w_pop;

  entry_t          r_mem [DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;

  inst_immediate_gen u_imm_gen (
    .i_inst    (in_inst),
    .o_format  (w_format),
    .o_imm     (w_imm),
    .o_illegal (w_illegal)
  );

  assign w_entry = '{
    pc:      in_pc,
    format:  w_format,
    rd:      in_inst[RdLsb +: 5],
    rs1:     in_inst[Rs1Lsb +: 5],
    rs2:     in_inst[Rs2Lsb +: 5],
    imm:     w_imm,
    illegal: w_illegal
  };

  // Readiness depends on occupancy only, so out_ready never reaches in_ready
  assign in_ready  = (r_count < CntW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready & ~flush;
  assign w_pop     = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  assign w_head = r_mem[r_rd_ptr];

  // Data fields are forced to zero while empty so stale storage never leaks out
  always_comb begin
    out_pc      = '0;
    out_format  = R;
    out_rd      = '0;
    out_rs1     = '0;
    out_rs2     = '0;
    out_imm     = '0;
    out_illegal = 1'b0;
    if (out_valid) begin
      out_pc      = w_head.pc;
      out_format  = w_head.format;
      out_rd      = w_head.rd;
      out_rs1     = w_head.rs1;
      out_rs2     = w_head.rs2;
      out_imm     = w_head.imm;
      out_illegal = w_head.illegal;
    end
  end

  assign out_count = r_count;

endmodule

// File: tb/tb_inst_decode_buffer.sv
// Randomised and directed bench for inst_decode_buffer against a queue-based reference model.
module tb_inst_decode_buffer;
  import inst_decode_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  format_t     out_format;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [31:0] out_imm;
  logic        out_illegal;
  logic [2:0]  out_count;

  int nvec = 0;
  int nerr = 0;
  entry_t mq[$];

  logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h73, 7'h0F, 7'h63,
                           7'h23, 7'h33};

  inst_decode_buffer #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_format  (out_format),
    .out_rd      (out_rd),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_imm     (out_imm),
    .out_illegal (out_illegal),
    .out_count   (out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference decode: immediates built as narrow signed values and widened arithmetically
  function automatic entry_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    entry_t e;
    logic signed [20:0] j21;
    logic signed [12:0] b13;
    logic signed [11:0] s12;
    int v;
    e = '0;
    e.pc = pc;
    e.rd = w[11:7];
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    case (w[6:0])
      7'h37, 7'h17: begin e.format = U; e.imm = w & 32'hFFFF_F000; end
      7'h6F: begin
        j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        v = j21; e.format = J; e.imm = v;
      end
      7'h67, 7'h03, 7'h13, 7'h73, 7'h0F: begin
        s12 = w[31:20]; v = s12; e.format = I; e.imm = v;
      end
      7'h63: begin
        b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        v = b13; e.format = B; e.imm = v;
      end
      7'h23: begin
        s12 = {w[31:25], w[11:7]}; v = s12; e.format = S; e.imm = v;
      end
      7'h33: begin e.format = R; e.imm = 0; end
      default: begin e.format = ILLEGAL; e.imm = 0; e.illegal = 1'b1; end
    endcase
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
    end else if (flush) begin
      mq.delete();
    end else begin
      logic do_push;
      do_push = in_valid && (mq.size() < DEPTH);
      if (mq.size() != 0 && out_ready) void'(mq.pop_front());
      if (do_push) mq.push_back(ref_decode(in_inst, in_pc));
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      entry_t h;
      h = (mq.size() != 0) ? mq[0] : '0;
      chk("out_valid", out_valid, mq.size() != 0);
      chk("in_ready", in_ready, mq.size() < DEPTH);
      chk("out_count", out_count, mq.size());
      chk("out_pc", out_pc, h.pc);
      chk("out_format", out_format, h.format);
      chk("out_rd", out_rd, h.rd);
      chk("out_rs1", out_rs1, h.rs1);
      chk("out_rs2", out_rs2, h.rs2);
      chk("out_imm", out_imm, h.imm);
      chk("out_illegal", out_illegal, h.illegal);
    end
  end

  task automatic step(input logic v, input logic [31:0] w, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    in_valid = v;
    in_inst = w;
    in_pc = pc;
    out_ready = ordy;
    flush = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    entry_t e;

    // Pin the reference model with hand-decoded words
    e = ref_decode(32'hFFF0_0093, 32'h100);
    chk("pin_addi_fmt", e.format, I);
    chk("pin_addi_imm", e.imm, 32'hFFFF_FFFF);
    chk("pin_addi_rd", e.rd, 5'd1);
    e = ref_decode(32'h1234_52B7, 32'h0);
    chk("pin_lui_imm", e.imm, 32'h1234_5000);
    e = ref_decode(32'hFE20_8EE3, 32'h0);
    chk("pin_beq_imm", e.imm, 32'hFFFF_FFFC);
    chk("pin_beq_rs", {e.rs1, e.rs2}, {5'd1, 5'd2});
    e = ref_decode(32'h0020_A423, 32'h0);
    chk("pin_sw_imm", e.imm, 32'h0000_0008);
    e = ref_decode(32'h0000_006F | 32'h8000_0000, 32'h0);
    chk("pin_jal_neg", e.imm, 32'hFFF0_0000);

    #3;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_count", out_count, 3'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single addi
    step(1, 32'hFFF0_0093, 32'h100, 1, 0);
    chk("addi_valid", out_valid, 1'b1);
    chk("addi_fmt", out_format, I);
    chk("addi_rd", out_rd, 5'd1);
    chk("addi_rs1", out_rs1, 5'd0);
    chk("addi_imm", out_imm, 32'hFFFF_FFFF);
    chk("addi_pc", out_pc, 32'h100);
    chk("addi_ill", out_illegal, 1'b0);
    step(0, 0, 0, 1, 0);

    // lui / beq / sw in order
    step(1, 32'h1234_52B7, 32'h200, 0, 0);
    step(1, 32'hFE20_8EE3, 32'h204, 0, 0);
    step(1, 32'h0020_A423, 32'h208, 0, 0);
    chk("seq_u_fmt", out_format, U);
    chk("seq_u_rd", out_rd, 5'd5);
    chk("seq_u_imm", out_imm, 32'h1234_5000);
    step(0, 0, 0, 1, 0);
    chk("seq_b_fmt", out_format, B);
    chk("seq_b_imm", out_imm, 32'hFFFF_FFFC);
    step(0, 0, 0, 1, 0);
    chk("seq_s_fmt", out_format, S);
    chk("seq_s_imm", out_imm, 32'h0000_0008);
    step(0, 0, 0, 1, 0);

    // Fill to full, fifth word held off
    for (int k = 0; k < 5; k++) step(1, 32'h0000_0013 | (k << 20), 32'h300 + 4 * k, 0, 0);
    chk("full_count", out_count, 3'd4);
    chk("full_ready", in_ready, 1'b0);
    step(1, 32'h0040_0013, 32'h310, 1, 0);
    chk("after_pop_ready", in_ready, 1'b1);
    chk("after_pop_count", out_count, 3'd3);
    step(1, 32'h0040_0013, 32'h310, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("pre_pp_count", out_count, 3'd2);
    step(1, 32'h0050_0013, 32'h314, 1, 0);
    chk("pushpop_count", out_count, 3'd2);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 0);

    // Pointer wrap with out_ready toggling
    for (int k = 0; k < 14; k++) step(k < 10, 32'h0000_0033 | (k << 7), 32'h400 + 4 * k, k[0], 0);
    for (int k = 0; k < 8; k++) step(0, 0, 0, 1, 0);

    // Flush at count 3 with concurrent push and pop
    for (int k = 0; k < 3; k++) step(1, 32'h0000_0093 | (k << 20), 32'h500 + 4 * k, 0, 0);
    step(1, 32'hDEAD_B0B7, 32'h50C, 1, 1);
    chk("flush_count", out_count, 3'd0);
    chk("flush_valid", out_valid, 1'b0);
    for (int k = 0; k < 2; k++) step(0, 0, 0, 1, 0);

    // Illegal words, then async reset mid-stream
    step(1, 32'h0000_0000, 32'h600, 0, 0);
    step(1, 32'h0000_007F, 32'h604, 0, 0);
    chk("ill_flag", out_illegal, 1'b1);
    chk("ill_fmt", out_format, ILLEGAL);
    chk("ill_imm", out_imm, 32'h0);
    chk("ill_count", out_count, 3'd2);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_ready", in_ready, 1'b1);
    chk("arst_count", out_count, 3'd0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Randomised traffic
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(3) != 0) w[6:0] = ops[$urandom_range(10)];
      step($urandom_range(3) != 0, w, $urandom & 32'hFFFF_FFFC, $urandom_range(1),
           $urandom_range(31) == 0);
    end
    for (int k = 0; k < 6; k++) step(0, 0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
